// File: rtl/generic_tb_rtl_dma_loopback.sv
// generic_tb_rtl_dma_loopback: DMA loopback test accelerator.
// Reads N words starting at conf_info_reg0 in bursts of up to BURST_LEN words,
// buffers each burst locally, then writes it back starting at conf_info_reg2.
// Build macro GENERIC_TB_INVERT_EN: write data is the bitwise inverse of the read data.
// Without it the data is copied unchanged. Control flow and timing match in both builds.
module generic_tb_rtl_dma_loopback #(
    parameter int unsigned DMA_WIDTH = 32,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned LEN_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          conf_info_reg0,
    input  logic [31:0]          conf_info_generic_tb_n,
    input  logic [31:0]          conf_info_reg2,
    input  logic                 conf_done,
    output logic                 dma_read_ctrl_valid,
    input  logic                 dma_read_ctrl_ready,
    output logic [31:0]          dma_read_ctrl_data_index,
    output logic [31:0]          dma_read_ctrl_data_length,
    output logic [2:0]           dma_read_ctrl_data_size,
    input  logic                 dma_read_chnl_valid,
    output logic                 dma_read_chnl_ready,
    input  logic [DMA_WIDTH-1:0] dma_read_chnl_data,
    output logic                 dma_write_ctrl_valid,
    input  logic                 dma_write_ctrl_ready,
    output logic [31:0]          dma_write_ctrl_data_index,
    output logic [31:0]          dma_write_ctrl_data_length,
    output logic [2:0]           dma_write_ctrl_data_size,
    output logic                 dma_write_chnl_valid,
    input  logic                 dma_write_chnl_ready,
    output logic [DMA_WIDTH-1:0] dma_write_chnl_data,
    output logic                 acc_done,
    output logic [31:0]          debug
);

    localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [2:0]  SIZE_CODE = (DMA_WIDTH == 64) ? 3'b011 : 3'b010;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   rd_base_q, rd_base_d;
    logic [LEN_WIDTH-1:0]   wr_base_q, wr_base_d;
    logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]   offset_q, offset_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [CNT_W-1:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0]       rcnt_q, rcnt_d;
    logic [15:0]            bursts_q, bursts_d;

    logic                   rd_ctrl_valid_d;
    logic [31:0]            rd_ctrl_index_d;
    logic [31:0]            rd_ctrl_len_d;
    logic                   rd_chnl_ready_d;
    logic                   wr_ctrl_valid_d;
    logic [31:0]            wr_ctrl_index_d;
    logic [31:0]            wr_ctrl_len_d;
    logic                   wr_chnl_valid_d;
    logic [DMA_WIDTH-1:0]   wr_data_d;
    logic                   acc_done_d;

    logic [LEN_WIDTH-1:0]   rem_after;
    logic [LEN_WIDTH-1:0]   off_after;
    logic [IDX_W-1:0]       rd_ptr;
    logic                   load_word;

    logic [DMA_WIDTH-1:0]   buf_mem [BURST_LEN];

    assign dma_read_ctrl_data_size  = SIZE_CODE;
    assign dma_write_ctrl_data_size = SIZE_CODE;

    // Burst length: whatever is left, capped at the buffer depth.
    function automatic logic [LEN_WIDTH-1:0] clip_len(input logic [LEN_WIDTH-1:0] rem);
        clip_len = (rem < LEN_WIDTH'(BURST_LEN)) ? rem : LEN_WIDTH'(BURST_LEN);
    endfunction

    // Burst buffer: captures read beats; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (state_q == RD_DATA && dma_read_chnl_valid && dma_read_chnl_ready) begin
            buf_mem[wcnt_q[IDX_W-1:0]] <= dma_read_chnl_data;
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q                    <= IDLE;
            rd_base_q                  <= '0;
            wr_base_q                  <= '0;
            remaining_q                <= '0;
            offset_q                   <= '0;
            len_q                      <= '0;
            wcnt_q                     <= '0;
            rcnt_q                     <= '0;
            bursts_q                   <= '0;
            dma_read_ctrl_valid        <= 1'b0;
            dma_read_ctrl_data_index   <= '0;
            dma_read_ctrl_data_length  <= '0;
            dma_read_chnl_ready        <= 1'b0;
            dma_write_ctrl_valid       <= 1'b0;
            dma_write_ctrl_data_index  <= '0;
            dma_write_ctrl_data_length <= '0;
            dma_write_chnl_valid       <= 1'b0;
            dma_write_chnl_data        <= '0;
            acc_done                   <= 1'b0;
            debug                      <= '0;
        end else begin
            state_q                    <= state_d;
            rd_base_q                  <= rd_base_d;
            wr_base_q                  <= wr_base_d;
            remaining_q                <= remaining_d;
            offset_q                   <= offset_d;
            len_q                      <= len_d;
            wcnt_q                     <= wcnt_d;
            rcnt_q                     <= rcnt_d;
            bursts_q                   <= bursts_d;
            dma_read_ctrl_valid        <= rd_ctrl_valid_d;
            dma_read_ctrl_data_index   <= rd_ctrl_index_d;
            dma_read_ctrl_data_length  <= rd_ctrl_len_d;
            dma_read_chnl_ready        <= rd_chnl_ready_d;
            dma_write_ctrl_valid       <= wr_ctrl_valid_d;
            dma_write_ctrl_data_index  <= wr_ctrl_index_d;
            dma_write_ctrl_data_length <= wr_ctrl_len_d;
            dma_write_chnl_valid       <= wr_chnl_valid_d;
            dma_write_chnl_data        <= wr_data_d;
            acc_done                   <= acc_done_d;
            debug                      <= {4'(state_d), 12'd0, bursts_d};
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d         = state_q;
        rd_base_d       = rd_base_q;
        wr_base_d       = wr_base_q;
        remaining_d     = remaining_q;
        offset_d        = offset_q;
        len_d           = len_q;
        wcnt_d          = wcnt_q;
        rcnt_d          = rcnt_q;
        bursts_d        = bursts_q;
        rd_ctrl_valid_d = dma_read_ctrl_valid;
        rd_ctrl_index_d = dma_read_ctrl_data_index;
        rd_ctrl_len_d   = dma_read_ctrl_data_length;
        rd_chnl_ready_d = dma_read_chnl_ready;
        wr_ctrl_valid_d = dma_write_ctrl_valid;
        wr_ctrl_index_d = dma_write_ctrl_data_index;
        wr_ctrl_len_d   = dma_write_ctrl_data_length;
        wr_chnl_valid_d = dma_write_chnl_valid;
        wr_data_d       = dma_write_chnl_data;
        acc_done_d      = 1'b0;
        rem_after       = remaining_q - len_q;
        off_after       = offset_q + len_q;
        rd_ptr          = '0;
        load_word       = 1'b0;

        case (state_q)
            IDLE: begin
                if (conf_done) begin
                    rd_base_d   = LEN_WIDTH'(conf_info_reg0);
                    wr_base_d   = LEN_WIDTH'(conf_info_reg2);
                    remaining_d = LEN_WIDTH'(conf_info_generic_tb_n);
                    offset_d    = '0;
                    bursts_d    = '0;
                    if (conf_info_generic_tb_n == 32'd0) begin
                        state_d    = DONE;
                        acc_done_d = 1'b1;
                    end else begin
                        state_d         = RD_REQ;
                        len_d           = clip_len(LEN_WIDTH'(conf_info_generic_tb_n));
                        rd_ctrl_valid_d = 1'b1;
                        rd_ctrl_index_d = conf_info_reg0;
                        rd_ctrl_len_d   = 32'(clip_len(LEN_WIDTH'(conf_info_generic_tb_n)));
                    end
                end
            end
            RD_REQ: begin
                if (dma_read_ctrl_ready) begin
                    state_d         = RD_DATA;
                    rd_ctrl_valid_d = 1'b0;
                    rd_chnl_ready_d = 1'b1;
                    wcnt_d          = '0;
                end
            end
            RD_DATA: begin
                if (dma_read_chnl_valid && dma_read_chnl_ready) begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                    if (LEN_WIDTH'(wcnt_q) + LEN_WIDTH'(1) == len_q) begin
                        state_d         = WR_REQ;
                        rd_chnl_ready_d = 1'b0;
                        wr_ctrl_valid_d = 1'b1;
                        wr_ctrl_index_d = 32'(wr_base_q + offset_q);
                        wr_ctrl_len_d   = 32'(len_q);
                    end
                end
            end
            WR_REQ: begin
                if (dma_write_ctrl_ready) begin
                    state_d         = WR_DATA;
                    wr_ctrl_valid_d = 1'b0;
                    wr_chnl_valid_d = 1'b1;
                    rcnt_d          = '0;
                    rd_ptr          = '0;
                    load_word       = 1'b1;
                end
            end
            WR_DATA: begin
                if (dma_write_chnl_ready) begin
                    if (LEN_WIDTH'(rcnt_q) + LEN_WIDTH'(1) == len_q) begin
                        wr_chnl_valid_d = 1'b0;
                        offset_d        = off_after;
                        remaining_d     = rem_after;
                        bursts_d        = bursts_q + 16'd1;
                        if (rem_after == '0) begin
                            state_d    = DONE;
                            acc_done_d = 1'b1;
                        end else begin
                            state_d         = RD_REQ;
                            len_d           = clip_len(rem_after);
                            rd_ctrl_valid_d = 1'b1;
                            rd_ctrl_index_d = 32'(rd_base_q + off_after);
                            rd_ctrl_len_d   = 32'(clip_len(rem_after));
                        end
                    end else begin
                        rcnt_d    = rcnt_q + CNT_W'(1);
                        rd_ptr    = IDX_W'(rcnt_q + CNT_W'(1));
                        load_word = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_word) begin
`ifdef GENERIC_TB_INVERT_EN
            wr_data_d = ~buf_mem[rd_ptr];
`else
            wr_data_d = buf_mem[rd_ptr];
`endif
        end
    end

endmodule

// File: tb/tb_generic_tb_rtl_dma_loopback.sv
// Bench for generic_tb_rtl_dma_loopback: a randomly stalling DMA responder plus a
// job-level model of the expected bursts and write data.
module tb_generic_tb_rtl_dma_loopback;

    localparam int unsigned DW     = 32;
    localparam int unsigned BL     = 16;
    localparam int unsigned BUDGET = 4000;

    logic          clk;
    logic          rst;
    logic [31:0]   conf_info_reg0;
    logic [31:0]   conf_info_generic_tb_n;
    logic [31:0]   conf_info_reg2;
    logic          conf_done;
    logic          dma_read_ctrl_valid;
    logic          dma_read_ctrl_ready;
    logic [31:0]   dma_read_ctrl_data_index;
    logic [31:0]   dma_read_ctrl_data_length;
    logic [2:0]    dma_read_ctrl_data_size;
    logic          dma_read_chnl_valid;
    logic          dma_read_chnl_ready;
    logic [DW-1:0] dma_read_chnl_data;
    logic          dma_write_ctrl_valid;
    logic          dma_write_ctrl_ready;
    logic [31:0]   dma_write_ctrl_data_index;
    logic [31:0]   dma_write_ctrl_data_length;
    logic [2:0]    dma_write_ctrl_data_size;
    logic          dma_write_chnl_valid;
    logic          dma_write_chnl_ready;
    logic [DW-1:0] dma_write_chnl_data;
    logic          acc_done;
    logic [31:0]   debug;

    int unsigned   n_assert = 0;
    int unsigned   n_fail   = 0;
    int unsigned   cyc      = 0;
    int unsigned   stall_pct = 0;
    int unsigned   ctrl_seen = 0;
    int unsigned   acc_cnt   = 0;
    int unsigned   last_wr_cyc = 0;
    int unsigned   conf_cyc  = 0;
    logic [31:0]   data_add  = 32'd0;

    logic [63:0]   exp_rd[$];
    logic [63:0]   exp_wr[$];
    logic [63:0]   obs_rd[$];
    logic [63:0]   obs_wr[$];
    logic [DW-1:0] exp_wd[$];
    logic [DW-1:0] obs_wd[$];
    logic [DW-1:0] rd_beats[$];

    generic_tb_rtl_dma_loopback #(.DMA_WIDTH(DW), .BURST_LEN(BL), .LEN_WIDTH(32)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .conf_info_reg0             (conf_info_reg0),
        .conf_info_generic_tb_n     (conf_info_generic_tb_n),
        .conf_info_reg2             (conf_info_reg2),
        .conf_done                  (conf_done),
        .dma_read_ctrl_valid        (dma_read_ctrl_valid),
        .dma_read_ctrl_ready        (dma_read_ctrl_ready),
        .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
        .dma_read_chnl_valid        (dma_read_chnl_valid),
        .dma_read_chnl_ready        (dma_read_chnl_ready),
        .dma_read_chnl_data         (dma_read_chnl_data),
        .dma_write_ctrl_valid       (dma_write_ctrl_valid),
        .dma_write_ctrl_ready       (dma_write_ctrl_ready),
        .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
        .dma_write_chnl_valid       (dma_write_chnl_valid),
        .dma_write_chnl_ready       (dma_write_chnl_ready),
        .dma_write_chnl_data        (dma_write_chnl_data),
        .acc_done                   (acc_done),
        .debug                      (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory image: word at index a is a + data_add.
    function automatic logic [DW-1:0] mem_word(input logic [31:0] a);
        mem_word = DW'(a + data_add);
    endfunction

    function automatic logic [DW-1:0] expect_word(input logic [DW-1:0] d);
`ifdef GENERIC_TB_INVERT_EN
        expect_word = ~d;
`else
        expect_word = d;
`endif
    endfunction

    function automatic logic go();
        go = ($urandom_range(99) >= stall_pct);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_ctrl_valid"}, 64'(dma_read_ctrl_valid), 64'd0);
        chk({tag, "_rd_ctrl_index"}, 64'(dma_read_ctrl_data_index), 64'd0);
        chk({tag, "_rd_ctrl_len"}, 64'(dma_read_ctrl_data_length), 64'd0);
        chk({tag, "_rd_chnl_ready"}, 64'(dma_read_chnl_ready), 64'd0);
        chk({tag, "_wr_ctrl_valid"}, 64'(dma_write_ctrl_valid), 64'd0);
        chk({tag, "_wr_ctrl_index"}, 64'(dma_write_ctrl_data_index), 64'd0);
        chk({tag, "_wr_ctrl_len"}, 64'(dma_write_ctrl_data_length), 64'd0);
        chk({tag, "_wr_chnl_valid"}, 64'(dma_write_chnl_valid), 64'd0);
        chk({tag, "_wr_chnl_data"}, 64'(dma_write_chnl_data), 64'd0);
        chk({tag, "_acc_done"}, 64'(acc_done), 64'd0);
        chk({tag, "_debug"}, 64'(debug), 64'd0);
    endtask

    // Build expected bursts/data for one job and issue conf_done.
    task automatic start_job(input logic [31:0] rd, input logic [31:0] wr, input logic [31:0] n);
        logic [31:0] off;
        logic [31:0] rem;
        logic [31:0] l;
        @(negedge clk);
        exp_rd.delete(); exp_wr.delete(); exp_wd.delete();
        obs_rd.delete(); obs_wr.delete(); obs_wd.delete();
        ctrl_seen = 0;
        acc_cnt   = 0;
        off = 32'd0;
        rem = n;
        while (rem != 32'd0) begin
            l = (rem < 32'(BL)) ? rem : 32'(BL);
            exp_rd.push_back({rd + off, l});
            exp_wr.push_back({wr + off, l});
            off = off + l;
            rem = rem - l;
        end
        for (int unsigned i = 0; i < n; i++) exp_wd.push_back(expect_word(mem_word(rd + 32'(i))));
        conf_info_reg0         = rd;
        conf_info_reg2         = wr;
        conf_info_generic_tb_n = n;
        conf_done              = 1'b1;
        conf_cyc               = cyc;
        @(negedge clk);
        conf_done = 1'b0;
        chk("first_rd_valid", 64'(dma_read_ctrl_valid), 64'(n != 32'd0));
    endtask

    // Wait for acc_done and compare the observed traffic with the model.
    task automatic finish_job(input logic [31:0] n);
        int unsigned k;
        k = 0;
        while (acc_done !== 1'b1 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        chk("acc_done_seen", 64'(acc_done), 64'd1);
        if (acc_done === 1'b1) begin
            if (n == 32'd0) chk("done_latency_n0", 64'(cyc), 64'(conf_cyc + 1));
            else            chk("done_latency", 64'(cyc), 64'(last_wr_cyc + 1));
            chk("debug_bursts", 64'(debug[15:0]), 64'(exp_rd.size()));
            chk("debug_pad", 64'(debug[27:16]), 64'd0);
        end
        @(negedge clk);
        chk("acc_done_one_cycle", 64'(acc_done), 64'd0);
        chk("rd_req_count", 64'(obs_rd.size()), 64'(exp_rd.size()));
        chk("wr_req_count", 64'(obs_wr.size()), 64'(exp_wr.size()));
        chk("wr_beat_count", 64'(obs_wd.size()), 64'(exp_wd.size()));
        foreach (exp_rd[i]) if (i < obs_rd.size()) chk("rd_req_idx_len", obs_rd[i], exp_rd[i]);
        foreach (exp_wr[i]) if (i < obs_wr.size()) chk("wr_req_idx_len", obs_wr[i], exp_wr[i]);
        foreach (exp_wd[i]) if (i < obs_wd.size()) chk("wr_data", 64'(obs_wd[i]), 64'(exp_wd[i]));
        if (n == 32'd0) chk("no_ctrl_valid_n0", 64'(ctrl_seen), 64'd0);
    endtask

    // DMA responder: random ready/valid stalls; logs every handshake and checks hold rules.
    initial begin : responder
        logic        rd_fire;
        logic        have_prev;
        logic        p_rcv, p_rcf, p_wcv, p_wcf, p_wdv, p_wdf;
        logic [63:0] p_rc, p_wc;
        logic [DW-1:0] p_wd;
        rd_fire = 1'b0;
        have_prev = 1'b0;
        {p_rcv, p_rcf, p_wcv, p_wcf, p_wdv, p_wdf} = '0;
        p_rc = '0; p_wc = '0; p_wd = '0;
        dma_read_ctrl_ready  = 1'b0;
        dma_write_ctrl_ready = 1'b0;
        dma_write_chnl_ready = 1'b0;
        dma_read_chnl_valid  = 1'b0;
        dma_read_chnl_data   = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                dma_read_ctrl_ready  = 1'b0;
                dma_write_ctrl_ready = 1'b0;
                dma_write_chnl_ready = 1'b0;
                dma_read_chnl_valid  = 1'b0;
                rd_beats.delete();
                rd_fire   = 1'b0;
                have_prev = 1'b0;
            end else begin
                if (acc_done === 1'b1) acc_cnt++;
                if (dma_read_ctrl_valid === 1'b1 || dma_write_ctrl_valid === 1'b1) ctrl_seen++;
                if (have_prev) begin
                    if (p_rcv && !p_rcf) begin
                        chk("rd_ctrl_hold_valid", 64'(dma_read_ctrl_valid), 64'd1);
                        chk("rd_ctrl_hold_fields", {dma_read_ctrl_data_index, dma_read_ctrl_data_length}, p_rc);
                    end
                    if (p_wcv && !p_wcf) begin
                        chk("wr_ctrl_hold_valid", 64'(dma_write_ctrl_valid), 64'd1);
                        chk("wr_ctrl_hold_fields", {dma_write_ctrl_data_index, dma_write_ctrl_data_length}, p_wc);
                    end
                    if (p_wdv && !p_wdf) begin
                        chk("wr_chnl_hold_valid", 64'(dma_write_chnl_valid), 64'd1);
                        chk("wr_chnl_hold_data", 64'(dma_write_chnl_data), 64'(p_wd));
                    end
                end
                // read data source
                if (rd_fire) begin
                    void'(rd_beats.pop_front());
                    dma_read_chnl_valid = 1'b0;
                end
                if (dma_read_chnl_ready === 1'b1) chk("rd_ready_only_with_beats_due", 64'(rd_beats.size() > 0), 64'd1);
                if (!dma_read_chnl_valid && rd_beats.size() > 0 && go()) begin
                    dma_read_chnl_valid = 1'b1;
                    dma_read_chnl_data  = rd_beats[0];
                end
                rd_fire = dma_read_chnl_valid && (dma_read_chnl_ready === 1'b1);
                // read request sink
                dma_read_ctrl_ready = go();
                if (dma_read_ctrl_valid === 1'b1 && dma_read_ctrl_ready) begin
                    obs_rd.push_back({dma_read_ctrl_data_index, dma_read_ctrl_data_length});
                    for (int i = 0; i < 64 && 32'(i) < dma_read_ctrl_data_length; i++)
                        rd_beats.push_back(mem_word(dma_read_ctrl_data_index + 32'(i)));
                end
                // write request sink
                dma_write_ctrl_ready = go();
                if (dma_write_ctrl_valid === 1'b1 && dma_write_ctrl_ready)
                    obs_wr.push_back({dma_write_ctrl_data_index, dma_write_ctrl_data_length});
                // write data sink
                dma_write_chnl_ready = go();
                if (dma_write_chnl_valid === 1'b1 && dma_write_chnl_ready) begin
                    obs_wd.push_back(dma_write_chnl_data);
                    last_wr_cyc = cyc;
                end
                p_rcv = (dma_read_ctrl_valid === 1'b1);
                p_rcf = p_rcv && dma_read_ctrl_ready;
                p_rc  = {dma_read_ctrl_data_index, dma_read_ctrl_data_length};
                p_wcv = (dma_write_ctrl_valid === 1'b1);
                p_wcf = p_wcv && dma_write_ctrl_ready;
                p_wc  = {dma_write_ctrl_data_index, dma_write_ctrl_data_length};
                p_wdv = (dma_write_chnl_valid === 1'b1);
                p_wdf = p_wdv && dma_write_chnl_ready;
                p_wd  = dma_write_chnl_data;
                have_prev = 1'b1;
            end
        end
    end

    // Directed sequence of jobs.
    initial begin : main
        int unsigned k;
        logic [31:0] n;
        rst                    = 1'b0;
        conf_info_reg0         = 32'd0;
        conf_info_reg2         = 32'd0;
        conf_info_generic_tb_n = 32'd0;
        conf_done              = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        chk("rd_size_code", 64'(dma_read_ctrl_data_size), 64'd2);
        chk("wr_size_code", 64'(dma_write_ctrl_data_size), 64'd2);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // N=0: no traffic, single done pulse
        start_job(32'h40, 32'h80, 32'd0);
        finish_job(32'd0);

        // N=5, data 1..5, no stalls
        stall_pct = 0;
        data_add  = 32'hFFFF_FF01;
        start_job(32'h100, 32'h200, 32'd5);
        finish_job(32'd5);

        // N=40: bursts 16,16,8; a stray conf_done mid-job is ignored
        data_add = $urandom;
        start_job(32'h100, 32'h400, 32'd40);
        repeat (4) @(negedge clk);
        conf_info_generic_tb_n = 32'd0;
        conf_info_reg0         = 32'hDEAD_0000;
        conf_done              = 1'b1;
        @(negedge clk);
        conf_done = 1'b0;
        finish_job(32'd40);

        // N=33 with random stalls everywhere
        stall_pct = 40;
        data_add  = $urandom;
        start_job($urandom, $urandom, 32'd33);
        finish_job(32'd33);

        // Reset in the middle of the second write burst, then a clean N=4 job
        stall_pct = 20;
        data_add  = $urandom;
        start_job(32'h1000, 32'h2000, 32'd40);
        k = 0;
        while (obs_wd.size() < 19 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        chk("reached_burst2_write", 64'(obs_wd.size() >= 19), 64'd1);
        rst     = 1'b0;
        acc_cnt = 0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_done_after_abort", 64'(acc_cnt), 64'd0);
        data_add = $urandom;
        start_job(32'h3000, 32'h4000, 32'd4);
        finish_job(32'd4);

        // Index wrap modulo 2^32 on both read and write sides
        stall_pct = 30;
        data_add  = $urandom;
        start_job(32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'd20);
        finish_job(32'd20);

        // Random jobs
        for (int t = 0; t < 4; t++) begin
            stall_pct = $urandom_range(60);
            data_add  = $urandom;
            n         = 32'($urandom_range(50, 1));
            start_job($urandom, $urandom, n);
            finish_job(n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
